// File: rtl/split_case_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : split_case_arb_if
// Brief    : Requester/result handshake bundle for the split_case_arb
//            round-robin add/sub sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface split_case_arb_if #(
    parameter int N_REQ = 3,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ*8-1:0] req_data;
    logic [N_REQ*2-1:0] req_sel;
    logic [N_REQ-1:0]   req_ready;
    logic               out_valid;
    logic               out_ready;
    logic [ID_W-1:0]    out_id;
    logic [7:0]         out_a;
    logic [7:0]         out_b;
    logic [15:0]        op_count;

    // Producer/consumer side: drives requests, consumes results
    modport master (
        output req_valid, req_data, req_sel, out_ready,
        input  req_ready, out_valid, out_id, out_a, out_b, op_count
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_data, req_sel, out_ready,
        output req_ready, out_valid, out_id, out_a, out_b, op_count
    );
endinterface
`default_nettype wire

// File: rtl/split_case_arb.sv
`default_nettype none
// ============================================================================
// Module   : split_case_arb
// Brief    : Round-robin arbiter sharing one split-case add/sub unit between
//            N_REQ byte requesters; single-entry back-pressured result reg.
// Revision : 1.0 - initial release
// ============================================================================
module split_case_arb #(
    parameter int N_REQ = 3,
    parameter int ID_W  = 2
) (
    input wire             clk,
    input wire             rst,
    split_case_arb_if.slave bus
);
    localparam int c_PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [c_PTR_W-1:0] r_rr_ptr;
    logic               r_out_valid;
    logic [ID_W-1:0]    r_out_id;
    logic [7:0]         r_out_a;
    logic [7:0]         r_out_b;
    logic [15:0]        r_op_count;

    logic               w_slot_free;
    logic [N_REQ-1:0]   w_grant;
    logic               w_found;
    logic [c_PTR_W-1:0] w_win_idx;
    logic [7:0]         w_win_data;
    logic [1:0]         w_win_sel;
    logic [7:0]         w_res_a;
    logic [7:0]         w_res_b;

    // (base + step) modulo N_REQ; base < N_REQ and step < N_REQ
    function automatic logic [c_PTR_W-1:0] ptr_wrap(input logic [c_PTR_W-1:0] base,
                                                    input int step);
        int s;
        s = int'(base) + step;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return c_PTR_W'(s);
    endfunction

    // The slot can take a new result when empty or being drained this cycle
    assign w_slot_free = !r_out_valid || bus.out_ready;

    // Round-robin scan starting at r_rr_ptr; first valid requester wins
    always_comb begin
        w_grant   = '0;
        w_found   = 1'b0;
        w_win_idx = '0;
        if (w_slot_free && !rst) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!w_found && bus.req_valid[ptr_wrap(r_rr_ptr, k)]) begin
                    w_found   = 1'b1;
                    w_win_idx = ptr_wrap(r_rr_ptr, k);
                end
            end
        end
        if (w_found) begin
            w_grant[w_win_idx] = 1'b1;
        end
    end

    assign w_win_data = bus.req_data[{w_win_idx, 3'b000} +: 8];
    assign w_win_sel  = bus.req_sel[{w_win_idx, 1'b0} +: 2];

    // Shared split-case datapath applied to the winner's byte
    always_comb begin
        w_res_a = w_win_data;
        w_res_b = w_win_data;
        case (w_win_sel)
            2'b00: begin
                w_res_a = w_win_data + 8'd5;
                w_res_b = w_win_data + 8'd6;
            end
            2'b01: begin
                w_res_a = w_win_data - 8'd5;
                w_res_b = w_win_data - 8'd6;
            end
            default: begin
                w_res_a = w_win_data;
                w_res_b = w_win_data;
            end
        endcase
    end

    // Result register, rotating pointer and accept counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_a     <= 8'hFF;
            r_out_b     <= 8'hAA;
            r_out_id    <= '0;
            r_rr_ptr    <= '0;
            r_op_count  <= 16'd0;
        end else if (w_found) begin
            r_out_valid <= 1'b1;
            r_out_a     <= w_res_a;
            r_out_b     <= w_res_b;
            r_out_id    <= ID_W'(w_win_idx);
            r_rr_ptr    <= ptr_wrap(w_win_idx, 1);
            r_op_count  <= r_op_count + 16'd1;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.out_valid = r_out_valid;
    assign bus.out_id    = r_out_id;
    assign bus.out_a     = r_out_a;
    assign bus.out_b     = r_out_b;
    assign bus.op_count  = r_op_count;

endmodule
`default_nettype wire

// File: doc/split_case_arb.md
# split_case_arb

Round-robin arbiter and sequencer that shares one split-case add/sub unit between `N_REQ` requesters. Each cycle it picks at most one requester and applies that requester's 2-bit operation select to its byte. It then returns the two results in a single-entry, back-pressured output register, tagged with the winner's index. It sits between several byte-stream producers and one shared case-select datapath instance, so the datapath is never duplicated per requester.

## Interface
Parameters:
- `N_REQ`, default 3, number of requesters (2..8).
- `ID_W`, default 2, width of `out_id`; must satisfy 2^ID_W >= N_REQ.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input N_REQ: per-requester request valid.
- `req_data` input N_REQ*8: requester i's byte in bits [8i+7:8i].
- `req_sel` input N_REQ*2: requester i's op select in bits [2i+1:2i].
- `req_ready` output N_REQ: one-hot or zero; combinational grant/accept.
- `out_valid` output 1: result register holds a valid result.
- `out_ready` input 1: consumer accepts the result this cycle.
- `out_id` output ID_W: index of the requester that produced the result.
- `out_a` output 8: primary result.
- `out_b` output 8: secondary result.
- `op_count` output 16: number of accepted requests since reset.

## Operation
- Op table, all arithmetic 8-bit modulo 256 with no saturation:
  - sel 2'b00: a = data+5, b = data+6.
  - sel 2'b01: a = data−5, b = data−6.
  - sel 2'b10 or 2'b11: a = data, b = data.
- `slot_free` = !out_valid || out_ready. The output register is loaded only when `slot_free` is true.
- Grant:
  - When `slot_free`, scan requesters from `rr_ptr` upward, wrapping at N_REQ−1 to 0.
  - The first i with `req_valid[i]` = 1 wins, and `req_ready[i]` = 1.
  - All other `req_ready` bits are 0.
  - If no request is valid or `slot_free` = 0, then `req_ready` = 0.
- A transfer happens on requester i when `req_valid[i]` && `req_ready[i]`.
- On transfer:
  - `out_a` and `out_b` load the op-table result of `req_data[i]`/`req_sel[i]`.
  - `out_id` <= i, `out_valid` <= 1.
  - `rr_ptr` <= (i+1) mod N_REQ.
  - `op_count` <= `op_count`+1, wrapping 16'hFFFF -> 0.
- With no transfer and `out_valid` && `out_ready`: `out_valid` <= 0. `out_a`, `out_b` and `out_id` hold their last values.
- With `out_valid` && !`out_ready`: all output fields hold stable and no grant is issued.
- `rr_ptr` changes only on a transfer. An idle cycle does not advance it.
- Requester side: `req_valid` does not depend on `req_ready`. A requester must hold its data and sel stable until accepted. The block does not check this; it samples only in the accept cycle.
- Invariant: `req_ready` is never asserted for a requester whose `req_valid` is 0.

## Timing
- Reset (`rst` = 1 at an edge) sets:
  - `out_valid` = 0, `out_a` = 8'hFF, `out_b` = 8'hAA, `out_id` = 0;
  - `rr_ptr` = 0, `op_count` = 0.
- During the reset cycle `req_ready` = 0 regardless of inputs.
- Reset mid-operation discards a pending result, with no output handshake. A request presented in the reset cycle is not accepted.
- `req_ready` is combinational from `req_valid`, `rr_ptr`, `out_valid` and `out_ready`. There is no combinational path from `req_data` or `req_sel` to any output.
- Latency: a request accepted at edge k is visible on `out_*` with `out_valid` = 1 immediately after edge k, i.e. in cycle k+1.
- Throughput: 1 result per cycle while `out_ready` = 1. Simultaneous pop and push in the same cycle is allowed, with no bubble.
- Fairness: with all N_REQ requesters continuously valid and `out_ready` = 1, grants rotate 0,1,...,N_REQ−1,0. Any requester waits at most N_REQ−1 transfers.

## Test plan
- Reset values: assert `rst` for 2 cycles with all `req_valid` = 1. Required: `req_ready` = 0, `out_valid` = 0, `out_a` = FF, `out_b` = AA, `op_count` = 0.
- Op table and wrap, with single requester 0 and `out_ready` = 1:
  - data 8'h10 sel 00 -> a = 15, b = 16.
  - data 8'h03 sel 01 -> a = FE, b = FD.
  - data 8'hFC sel 00 -> a = 01, b = 02.
  - data 8'h7E sel 11 -> a = 7E, b = 7E.
- Round robin: all three requesters valid continuously, `out_ready` = 1, for 7 cycles. Required: `out_id` sequence 0,1,2,0,1,2,0 and `op_count` = 7.
- Back-pressure: result pending, `out_ready` = 0 for 4 cycles while requesters 1 and 2 are valid. Required: `req_ready` = 0 throughout and outputs stable. On release, the pending result pops and requester 1 is granted in the same cycle.
- Idle pointer: grant requester 2, then idle 3 cycles, then only requester 1 valid. Required: requester 1 is granted and `rr_ptr` becomes 2. Then all three valid -> order 2,0,1.
- Reset mid-stream: `rst` while `out_valid` = 1 and `out_ready` = 0. Required: next cycle `out_valid` = 0, `op_count` = 0, and the first grant after reset goes to requester 0.
